id_ex_pipe_reg: RTL
===================

Name: id_ex_pipe_reg

Overview:
- Decode-to-execute pipeline register of the 5-stage core.
- Captures register-file read data, register specifiers, immediate and control bits from D; presents them to E.
- Its RFRD1E/RFRD2E outputs feed the E-stage forwarding muxes, and its RsE/RtE outputs feed the hazard unit.
- Supports stall (hold), flush (bubble insertion) and valid tracking, plus saturating bubble and stall event counters for performance debug.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register specifier width.
- ALUCTL_W, 3, ALU control field width.
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- StallE  input  1  hold all E outputs this cycle.
- FlushE  input  1  load a bubble this cycle.
- ValidD  input  1  D-stage holds a real instruction.
- RFRD1D, RFRD2D  input  DATA_W  register-file read data.
- SignImmD  input  DATA_W  sign-extended immediate.
- PCPlus4D  input  DATA_W  PC+4 of the D instruction.
- RsD, RtD, RdD  input  REG_AW  register specifiers.
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  input  1 each  control bits.
- ALUControlD  input  ALUCTL_W  ALU operation.
- RFRD1E, RFRD2E, SignImmE, PCPlus4E  output  DATA_W  registered copies.
- RsE, RtE, RdE  output  REG_AW  registered copies.
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  output  1 each  registered control.
- ALUControlE  output  ALUCTL_W  registered ALU operation.
- ValidE  output  1  E-stage holds a real instruction.
- BubbleCnt  output  CNT_W  count of cycles in which a bubble was loaded.
- StallCnt  output  CNT_W  count of cycles in which E was held.

Behaviour:
- Reset: asynchronous on rst_n low. All outputs go to 0, including ValidE, BubbleCnt and StallCnt. The register holds 0 for as long as rst_n is low.
- Each rising clk with rst_n high applies exactly one action, highest priority first:
  1. FlushE=1 → bubble. All control outputs, ValidE and every data/specifier output are loaded with 0. Flush wins over StallE.
  2. StallE=1 (FlushE=0) → hold. Every output, including ValidE, keeps its value.
  3. Otherwise → load. Every E output takes the matching D input on this edge; ValidE takes ValidD.
- Latency: 1 cycle from D inputs to E outputs. There is no combinational path from any input to any output.
- ValidD=0 on a load cycle: control fields are still captured as presented (decode already zeroes them for invalid instructions); ValidE becomes 0.
- BubbleCnt: +1 on every edge where FlushE=1, whatever the value of StallE.
- StallCnt: +1 on every edge where StallE=1 and FlushE=0.
- Both counters saturate at all-ones (2^CNT_W−1) and never wrap. Software cannot clear them; only reset clears them.
- rst_n deasserting: the first rising edge after deassertion performs a normal action per the priority list above.
- rst_n asserted mid-stall or mid-flush: outputs clear immediately, with no wait for clk.

Decomposition:
- Shared pipeline package (pipe_pkg) holds DATA_W, REG_AW and ALUCTL_W, and a packed control-bundle typedef ctrl_t = {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, ALUControl}. D, E and M registers use this same bundle.
- One sub-module: sat_counter (CNT_W parameter, enable input, async active-low reset). It is instantiated twice, for BubbleCnt and StallCnt.
- The main register is a single always block over the packed bundle plus data fields.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with all D inputs at 0xFFFFFFFF → all outputs read 0 before the next clk edge.
- Load: RFRD2D=0x1234_5678, RtD=5'd9, RegWriteD=1, ValidD=1, no stall or flush → after one edge RFRD2E=0x12345678, RtE=9, RegWriteE=1, ValidE=1.
- Stall: with E loaded as above, hold StallE=1 for 3 edges while RFRD2D=0xDEADBEEF → RFRD2E stays 0x12345678 and StallCnt=3.
- Flush beats stall: FlushE=1 and StallE=1 on the same edge → ValidE=0, RegWriteE=0, MemWriteE=0, RFRD2E=0, BubbleCnt +1, StallCnt unchanged.
- Saturation: with CNT_W=4, hold FlushE=1 for 20 edges → BubbleCnt=0xF and stays 0xF.
- Load-use sequence: load an lw (MemtoRegD=1, RtD=8), then stall D with FlushE=1 for one edge → the E outputs show the lw, then a bubble (ValidE=0). The next load carries the dependent instruction with RsE=8.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths and the control/payload bundles
// carried between the D, E and M pipeline registers.
package pipe_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALUCTL_W = 3;

  typedef struct packed {
    logic                reg_write;
    logic                memto_reg;
    logic                mem_write;
    logic                alu_src;
    logic                reg_dst;
    logic [ALUCTL_W-1:0] alu_control;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] rfrd1;
    logic [DATA_W-1:0] rfrd2;
    logic [DATA_W-1:0] sign_imm;
    logic [DATA_W-1:0] pc_plus4;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } idex_t;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// D-side capture bus and E-side presentation bus of the ID/EX pipeline register.
interface id_ex_pipe_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic                StallE;
  logic                FlushE;
  logic                ValidD;
  logic [DATA_W-1:0]   RFRD1D, RFRD2D, SignImmD, PCPlus4D;
  logic [REG_AW-1:0]   RsD, RtD, RdD;
  logic                RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [ALUCTL_W-1:0] ALUControlD;

  logic [DATA_W-1:0]   RFRD1E, RFRD2E, SignImmE, PCPlus4E;
  logic [REG_AW-1:0]   RsE, RtE, RdE;
  logic                RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [ALUCTL_W-1:0] ALUControlE;
  logic                ValidE;
  logic [CNT_W-1:0]    BubbleCnt, StallCnt;

  modport master (
    output StallE, FlushE, ValidD, RFRD1D, RFRD2D, SignImmD, PCPlus4D,
           RsD, RtD, RdD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
           ALUControlD,
    input  RFRD1E, RFRD2E, SignImmE, PCPlus4E, RsE, RtE, RdE,
           RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           ValidE, BubbleCnt, StallCnt
  );

  modport slave (
    input  StallE, FlushE, ValidD, RFRD1D, RFRD2D, SignImmD, PCPlus4D,
           RsD, RtD, RdD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
           ALUControlD,
    output RFRD1E, RFRD2E, SignImmE, PCPlus4E, RsE, RtE, RdE,
           RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           ValidE, BubbleCnt, StallCnt
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that increments on enable and sticks at all-ones; cleared only by reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with stall/flush/valid tracking and
// saturating bubble/stall event counters.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_pipe_reg_if.slave  bus
);

  idex_t d_bus;
  idex_t e_q;

  // Pack the D-stage inputs into the shared payload bundle.
  always_comb begin
    d_bus                   = '0;
    d_bus.valid             = bus.ValidD;
    d_bus.ctrl.reg_write    = bus.RegWriteD;
    d_bus.ctrl.memto_reg    = bus.MemtoRegD;
    d_bus.ctrl.mem_write    = bus.MemWriteD;
    d_bus.ctrl.alu_src      = bus.ALUSrcD;
    d_bus.ctrl.reg_dst      = bus.RegDstD;
    d_bus.ctrl.alu_control  = bus.ALUControlD;
    d_bus.rfrd1             = bus.RFRD1D;
    d_bus.rfrd2             = bus.RFRD2D;
    d_bus.sign_imm          = bus.SignImmD;
    d_bus.pc_plus4          = bus.PCPlus4D;
    d_bus.rs                = bus.RsD;
    d_bus.rt                = bus.RtD;
    d_bus.rd                = bus.RdD;
  end

  // Flush loads an all-zero bubble and overrides stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
    end else if (bus.FlushE) begin
      e_q <= '0;
    end else if (!bus.StallE) begin
      e_q <= d_bus;
    end
  end

  assign bus.ValidE      = e_q.valid;
  assign bus.RegWriteE   = e_q.ctrl.reg_write;
  assign bus.MemtoRegE   = e_q.ctrl.memto_reg;
  assign bus.MemWriteE   = e_q.ctrl.mem_write;
  assign bus.ALUSrcE     = e_q.ctrl.alu_src;
  assign bus.RegDstE     = e_q.ctrl.reg_dst;
  assign bus.ALUControlE = e_q.ctrl.alu_control;
  assign bus.RFRD1E      = e_q.rfrd1;
  assign bus.RFRD2E      = e_q.rfrd2;
  assign bus.SignImmE    = e_q.sign_imm;
  assign bus.PCPlus4E    = e_q.pc_plus4;
  assign bus.RsE         = e_q.rs;
  assign bus.RtE         = e_q.rt;
  assign bus.RdE         = e_q.rd;

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.FlushE),
    .count (bus.BubbleCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.StallE & ~bus.FlushE),
    .count (bus.StallCnt)
  );

endmodule
